// File: rtl/mem_port_arbiter.sv
// Round-robin port sharing of the unified I/D memory between the CPU FSM and the boot loader.
// Each access is a 1-cycle mem_en, an ACC_LAT wait, a 1-cycle ack, and a DONE cycle. Optional ld_lock via MEM_PORT_ARBITER_LOCK_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ACC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
`ifdef MEM_PORT_ARBITER_LOCK_EN
  input  logic              ld_lock,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC_CPU, ACC_LD, DONE} state_t;

  localparam logic [3:0] LAT_C = 4'(ACC_LAT);

  state_t              state_q, state_d;
  logic                last_ld_q, last_ld_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                acc_we_q, acc_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ok;
  logic                grant_cpu;

`ifdef MEM_PORT_ARBITER_LOCK_EN
  assign cpu_ok = cpu_req && !ld_lock;
`else
  assign cpu_ok = cpu_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_ld_q   <= 1'b1;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      acc_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_ld_q   <= last_ld_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      acc_we_q    <= acc_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_ld_d   = last_ld_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    acc_we_d    = acc_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack     = 1'b0;
    ld_ack      = 1'b0;
    grant_cpu   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_ok || ld_req) begin
          // On a tie the requester that did not win last time goes first
          grant_cpu   = cpu_ok && (!ld_req || last_ld_q);
          state_d     = grant_cpu ? ACC_CPU : ACC_LD;
          last_ld_d   = !grant_cpu;
          cnt_d       = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_cpu ? cpu_we : ld_we;
          acc_we_d    = grant_cpu ? cpu_we : ld_we;
          mem_addr_d  = grant_cpu ? cpu_addr : ld_addr;
          mem_wdata_d = grant_cpu ? cpu_wdata : ld_wdata;
        end
      end
      ACC_CPU: begin
        if (cnt_q == LAT_C) begin
          cpu_ack = 1'b1;
          if (!acc_we_q) cpu_rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACC_LD: begin
        if (cnt_q == LAT_C) begin
          ld_ack  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // Gives the requester a cycle to drop req after its ack
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (ACC_LAT 1 and 4) with memory stubs, checked every cycle
// against a phase-count reference model, plus directed literal checks and a randomized phase.
module tb_mem_port_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  logic reset;
  logic        cpu_req [N], cpu_we [N], ld_req [N], ld_we [N];
  logic        cpu_ack [N], ld_ack [N], mem_en [N], mem_we [N];
  logic [31:0] cpu_addr [N], cpu_wdata [N], ld_addr [N], ld_wdata [N];
  logic [31:0] cpu_rdata [N], mem_addr [N], mem_wdata [N], mem_rdata [N];
`ifdef MEM_PORT_ARBITER_LOCK_EN
  logic        ld_lock [N];
`endif

  bit   [31:0] smem [N][256];
  bit          swr  [N][256];
  logic [31:0] sdat [N];
  int          scnt [N];

  int n_chk = 0;
  int n_fail = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] init_word(input int k);
    return (k == 4) ? 32'hDEADBEEF : (32'h1000_0000 | (32'(k) * 32'h0001_0101));
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ACC_LAT(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
      .ld_req(ld_req[g]), .ld_we(ld_we[g]), .ld_addr(ld_addr[g]), .ld_wdata(ld_wdata[g]),
      .ld_ack(ld_ack[g]),
`ifdef MEM_PORT_ARBITER_LOCK_EN
      .ld_lock(ld_lock[g]),
`endif
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
    // Read data is only valid in the exact cycle ACC_LAT after mem_en; junk otherwise
    assign mem_rdata[g] = (scnt[g] == lat_of(g)) ? sdat[g] : 32'hBAD0_0BAD;
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_en[i]) begin
        if (mem_we[i]) begin
          smem[i][mem_addr[i][9:2]] <= mem_wdata[i];
          swr[i][mem_addr[i][9:2]]  <= 1'b1;
        end
        sdat[i] <= swr[i][mem_addr[i][9:2]] ? smem[i][mem_addr[i][9:2]] : init_word(int'(mem_addr[i][9:2]));
        scnt[i] <= 1;
      end else if (scnt[i] != 0 && scnt[i] < 15) begin
        scnt[i] <= scnt[i] + 1;
      end
    end
  end

  // Reference model: cycles elapsed since the grant edge (0 = free) drive every expectation
  int          ph [N];
  bit          who_cpu [N], last_ld [N], lwe [N];
  logic [31:0] laddr [N], lwd [N], rdat [N];
  bit   [31:0] rmem [N][256];
  bit          rwr  [N][256];

  function automatic logic [31:0] ref_read(input int i, input logic [31:0] a);
    return rwr[i][a[9:2]] ? rmem[i][a[9:2]] : init_word(int'(a[9:2]));
  endfunction

  task automatic model_and_check();
    bit c, l;
    int L;
    logic [99:0] act, exp;
    for (int i = 0; i < N; i++) begin
      L = lat_of(i);
      if (reset) begin
        ph[i] = 0; last_ld[i] = 1'b1; lwe[i] = 1'b0;
        laddr[i] = '0; lwd[i] = '0; rdat[i] = '0;
      end else if (ph[i] == 0) begin
        c = cpu_req[i];
`ifdef MEM_PORT_ARBITER_LOCK_EN
        c = c && !ld_lock[i];
`endif
        l = ld_req[i];
        if (c || l) begin
          who_cpu[i] = c && (!l || last_ld[i]);
          last_ld[i] = !who_cpu[i];
          lwe[i]   = who_cpu[i] ? cpu_we[i] : ld_we[i];
          laddr[i] = who_cpu[i] ? cpu_addr[i] : ld_addr[i];
          lwd[i]   = who_cpu[i] ? cpu_wdata[i] : ld_wdata[i];
          ph[i] = 1;
        end
      end else begin
        ph[i]++;
        if (ph[i] == 2 && lwe[i]) begin
          rmem[i][laddr[i][9:2]] = lwd[i];
          rwr[i][laddr[i][9:2]]  = 1'b1;
        end
        if (ph[i] == L + 2 && who_cpu[i] && !lwe[i]) rdat[i] = ref_read(i, laddr[i]);
        if (ph[i] == L + 3) ph[i] = 0;
      end
      exp = {(ph[i] == L + 1) && who_cpu[i], (ph[i] == L + 1) && !who_cpu[i], ph[i] == 1,
             (ph[i] == 1) && lwe[i], laddr[i], lwd[i], rdat[i]};
      act = {cpu_ack[i], ld_ack[i], mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i], cpu_rdata[i]};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_check inst%0d t=%0t got ack=%b%b en=%b we=%b addr=%h wd=%h rd=%h expected ack=%b%b en=%b we=%b addr=%h wd=%h rd=%h",
                 i, $time, act[99], act[98], act[97], act[96], act[95:64], act[63:32], act[31:0],
                 exp[99], exp[98], exp[97], exp[96], exp[95:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_and_check();
    #1;
  endtask

  task automatic lit_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic sig_of(input int i, input int which);
    case (which)
      0: return mem_en[i];
      1: return cpu_ack[i];
      default: return ld_ack[i];
    endcase
  endfunction

  task automatic wait_sig(input int i, input int which, input int bound, input string name);
    bit found = 1'b0;
    for (int k = 0; k < bound && !found; k++) begin
      tick();
      found = sig_of(i, which);
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: got no event within %0d cycles, expected one", name, bound);
    end
  endtask

  task automatic rand_fields(output logic we, output logic [31:0] addr, output logic [31:0] wd);
    we   = 1'($urandom_range(0, 1));
    addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    wd   = $urandom;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      ld_req[i] = 0; ld_we[i] = 0; ld_addr[i] = '0; ld_wdata[i] = '0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
      ld_lock[i] = 0;
`endif
    end
  endtask

  initial begin
    int order [$];
    int acks;
    clear_inputs();
    reset = 1'b1;
    // Reset with every request high on both instances
    for (int i = 0; i < N; i++) begin
      cpu_req[i] = 1; cpu_addr[i] = 32'h10;
      ld_req[i] = 1; ld_addr[i] = 32'h20;
    end
    tick();
    lit_check("reset_strobes", {28'd0, cpu_ack[0], ld_ack[0], mem_en[0], mem_we[0]}, 32'h0);
    lit_check("reset_mem_addr", mem_addr[0], 32'h0);
    lit_check("reset_cpu_rdata", cpu_rdata[0], 32'h0);
    tick();
    reset = 1'b0;
    tick();
    lit_check("first_grant_mem_en", {31'd0, mem_en[0]}, 32'h1);
    lit_check("first_grant_cpu_addr", mem_addr[0], 32'h10);
    lit_check("first_grant_mem_we", {31'd0, mem_we[0]}, 32'h0);
    tick();
    lit_check("lw_cpu_ack_lat1", {31'd0, cpu_ack[0]}, 32'h1);
    order.push_back(0);
    tick();
    lit_check("lw_cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
    for (int k = 0; k < 40 && order.size() < 4; k++) begin
      tick();
      if (cpu_ack[0]) order.push_back(0);
      if (ld_ack[0]) order.push_back(1);
    end
    lit_check("tie_ack_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      lit_check($sformatf("tie_order_%0d", k), 32'(order[k]), 32'(k % 2));
    lit_check("lw_rdata_holding", cpu_rdata[0], 32'hDEADBEEF);
    clear_inputs();
    repeat (10) tick();

    // Loader write, then CPU fetch of the same word
    ld_req[0] = 1; ld_we[0] = 1; ld_addr[0] = 32'h0; ld_wdata[0] = 32'h00500093;
    wait_sig(0, 0, 10, "ld_write_mem_en");
    lit_check("ld_write_mem_we", {31'd0, mem_we[0]}, 32'h1);
    lit_check("ld_write_mem_wdata", mem_wdata[0], 32'h00500093);
    wait_sig(0, 2, 10, "ld_write_ack");
    ld_req[0] = 0;
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h0;
    wait_sig(0, 1, 10, "fetch_ack");
    cpu_req[0] = 0;
    tick();
    lit_check("fetch_rdata", cpu_rdata[0], 32'h00500093);

    // Reset two cycles into an ACC_LAT=4 access; the held request is granted again afterwards
    cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 32'h40;
    wait_sig(1, 0, 10, "midreset_mem_en");
    tick();
    tick();
    reset = 1'b1;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      acks += int'(cpu_ack[1]);
      if (k == 1) reset = 1'b0;
    end
    lit_check("midreset_no_ack", 32'(acks), 32'd0);
    wait_sig(1, 0, 10, "midreset_regrant");
    wait_sig(1, 1, 10, "midreset_ack");
    cpu_req[1] = 0;
    tick();
    lit_check("midreset_rdata", cpu_rdata[1], init_word(16));
    repeat (4) tick();

`ifdef MEM_PORT_ARBITER_LOCK_EN
    ld_lock[0] = 1; cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h10;
    acks = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      acks += int'(cpu_ack[0]) + int'(mem_en[0] && mem_addr[0] == 32'h10);
      if (ld_ack[0]) ld_req[0] = 0;
      if (k == 3) begin ld_req[0] = 1; ld_we[0] = 0; ld_addr[0] = 32'h80; end
    end
    lit_check("lock_cpu_blocked", 32'(acks), 32'd0);
    ld_lock[0] = 0;
    wait_sig(0, 1, 4, "lock_release_ack");
    clear_inputs();
    repeat (4) tick();
`endif

    // Randomized requesters on both instances
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (cpu_req[i]) begin
          if (cpu_ack[i] && $urandom_range(0, 1) == 0) cpu_req[i] = 0;
          else if (cpu_ack[i] || $urandom_range(0, 3) == 0) rand_fields(cpu_we[i], cpu_addr[i], cpu_wdata[i]);
        end else if ($urandom_range(0, 2) == 0) begin
          cpu_req[i] = 1;
          rand_fields(cpu_we[i], cpu_addr[i], cpu_wdata[i]);
        end
        if (ld_req[i]) begin
          if (ld_ack[i] && $urandom_range(0, 1) == 0) ld_req[i] = 0;
          else if (ld_ack[i] || $urandom_range(0, 3) == 0) rand_fields(ld_we[i], ld_addr[i], ld_wdata[i]);
        end else if ($urandom_range(0, 2) == 0) begin
          ld_req[i] = 1;
          rand_fields(ld_we[i], ld_addr[i], ld_wdata[i]);
        end
      end
    end
    clear_inputs();
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified instruction/data memory of the multicycle RISC-V core between two requesters: the control FSM/datapath (fetch and lw/sw accesses) and the boot program loader. It sequences each access into a one-cycle memory enable followed by a fixed-latency wait and a one-cycle acknowledge. It sits between the datapath memory-address mux (IorD) and the memory macro. The CPU FSM holds its current state until cpu_ack.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width
ACC_LAT, 1, memory access latency in cycles from mem_en to valid mem_rdata/write complete; legal values 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request, held high until cpu_ack
cpu_we  input  1  1 = write (sw), 0 = read (fetch/lw)
cpu_addr  input  ADDR_W  CPU byte address
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  CPU read data, registered, held until next CPU read ack
cpu_ack  output  1  one-cycle completion pulse to CPU
ld_req  input  1  loader request, held until ld_ack
ld_we  input  1  loader write enable
ld_addr  input  ADDR_W  loader address
ld_wdata  input  DATA_W  loader write data
ld_ack  output  1  one-cycle completion pulse to loader
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable, valid with mem_en
mem_addr  output  ADDR_W  registered memory address
mem_wdata  output  DATA_W  registered memory write data
mem_rdata  input  DATA_W  memory read data, valid ACC_LAT cycles after mem_en

Behaviour:
- Reset (async, any time, including mid-access): state IDLE, last_grant = LOADER, latency counter 0. cpu_ack, ld_ack, mem_en and mem_we are 0; mem_addr, mem_wdata and cpu_rdata are 0. Any in-flight access is abandoned with no ack.
- States: IDLE, ACC_CPU, ACC_LD, DONE.
- IDLE, on a rising edge:
  - Only cpu_req high: go to ACC_CPU.
  - Only ld_req high: go to ACC_LD.
  - Both high: grant the requester that is not last_grant (round robin). After reset the CPU wins the first tie.
  - On grant: latch addr, we and wdata into the mem_* registers, set mem_en=1, update last_grant.
- ACC_*: mem_en is high for exactly the first cycle, then 0. The counter counts ACC_LAT cycles from mem_en rising. When the count is reached:
  - Capture mem_rdata into cpu_rdata (CPU reads only; loader read data is discarded).
  - Pulse the granted requester's ack for one cycle.
  - Go to DONE.
- DONE: one idle cycle, so the requester can drop req after its ack. Then go to IDLE. A req still high in IDLE is treated as a new request.
- Latency:
  - Request sampled at edge N → mem_en high in cycle N+1 → ack high in cycle N+1+ACC_LAT.
  - Throughput is one access per ACC_LAT+3 cycles.
- Requests arriving during ACC_* or DONE wait; they are never lost while held high.
- Requester inputs are sampled only at grant. Changes after grant have no effect on the current access.
- cpu_ack and ld_ack are never high in the same cycle. mem_en never asserts outside ACC_*.
- cpu_rdata is unchanged by CPU writes and by all loader accesses.

Optional Feature:
- Macro: MEM_PORT_ARBITER_LOCK_EN.
- When defined: adds input ld_lock (1 bit).
  - While ld_lock=1 in IDLE, only ld_req can be granted; cpu_req waits, stalling the FSM.
  - Asserting ld_lock mid CPU access does not abort that access.
- When undefined: no ld_lock port; pure round robin.

Test Plan:
- Reset check: assert reset for 10 ns with all requests high → all outputs 0; after release, the first grant goes to the CPU.
- lw-style CPU read, ACC_LAT=1: cpu_req=1, cpu_we=0, cpu_addr=0x00000010, memory model returns 0xDEADBEEF.
  - Expected: mem_en one cycle after the sampling edge, mem_addr=0x10, mem_we=0.
  - Expected: cpu_ack one cycle later; cpu_rdata=0xDEADBEEF and holding.
- Tie round robin: cpu_req and ld_req both held high for 4 accesses → grant order CPU, LD, CPU, LD; acks never overlap.
- Loader write then CPU read: loader writes 0x00500093 to 0x0.
  - Expected: mem_we=1, mem_wdata=0x00500093, ld_ack.
  - Then: a CPU fetch of 0x0 returns 0x00500093.
- Mid-access reset with ACC_LAT=4: reset asserted 2 cycles after mem_en → no ack, state IDLE. A request held through reset is regranted after release.
- With MEM_PORT_ARBITER_LOCK_EN, ld_lock=1 and cpu_req high for 20 cycles → no cpu_ack and no CPU mem_en. ld_req is served. cpu_ack follows within ACC_LAT+3 cycles of ld_lock falling.
